hilo_muldiv_iter: RTL
=====================

// Module: hilo_muldiv_iter
// PURPOSE
//  Parametrised multi-cycle HI/LO multiply/divide unit that supersedes the single-cycle HI/LO block.
//  Executes MULT/MULTU with a shift-add datapath and DIV/DIVU with a restoring divider, one bit per
//  cycle, and holds the MIPS HI/LO registers. It sits beside the ALU in EX.
//  The control unit issues ops with start, and stalls MFHI/MFLO and new HI/LO ops while busy is high.
// PARAMETERS
//  WIDTH      32  operand and HI/LO register width (>=4); internal product/remainder is 2*WIDTH
//  FAST_MULT  0   1: MULT/MULTU complete combinationally at the start edge; 0: iterative
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-high; clears all state
//  start  in   1      issue op; sampled on clk edge, accepted only when busy==0
//  op     in   3      000 MTHI, 001 MTLO, 010 MULTU, 011 DIVU, 110 MULT, 111 DIV, 100/101 no-op
//  in_1   in   WIDTH  rs: multiplicand / dividend / MTHI-MTLO source
//  in_2   in   WIDTH  rt: multiplier / divisor
//  busy   out  1      iterative op in flight; hi/lo hold old values
//  done   out  1      one-cycle pulse: hi/lo show the new mul/div result this cycle
//  hi     out  WIDTH  HI register (product upper half / remainder)
//  lo     out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  - Reset (async): hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0. Reset mid-operation aborts
//    the op and discards its partial result.
//  - FSM states IDLE -> CALC -> FIX -> IDLE.
//  - IDLE, start=1, op MTHI/MTLO: write hi or lo from in_1 at that edge; busy stays 0; done stays 0.
//  - IDLE, start=1, op mul/div (iterative): latch operand magnitudes and sign flags, count=0, busy<=1,
//    state<=CALC. Signed ops (op[2]=1) use magnitudes |x|; the most-negative value's magnitude is
//    2^(WIDTH-1), taken unsigned.
//  - CALC: one iteration per cycle for exactly WIDTH cycles. Multiply: conditional add plus right shift.
//    Divide: restoring shift-subtract, one quotient bit per cycle. Then state<=FIX.
//  - FIX, one cycle: apply sign correction, write hi/lo, busy<=0, done<=1, state<=IDLE. busy is therefore
//    high for WIDTH+1 cycles, and hi/lo update WIDTH+1 edges after the accepting edge.
//  - FAST_MULT=1: MULT/MULTU write {hi,lo}=full 2*WIDTH product at the accepting edge; busy stays 0; done
//    pulses the following cycle. Divides remain iterative.
//  - Signed multiply: product negated (2*WIDTH two's complement) when the sign flags differ.
//  - Signed divide uses truncation: quotient negative iff signs differ; remainder takes the dividend's
//    sign; |rem| < |divisor|; in_1 = lo*in_2 + hi always holds.
//  - Signed overflow: MIN/-1 gives lo=MIN, hi=0, with no exception.
//  - Divide by zero (any sign): lo = all ones, hi = in_1 unchanged. Deterministic, no exception.
//  - start while busy=1 is ignored: no queueing, operands and op not captured. The control unit is
//    responsible for stalling.
//  - start with op 100/101: no state change. done is 0 in every cycle except the single pulse above.
//  - done and busy are never 1 in the same cycle. hi/lo never change while busy=1.
// TESTING
//  1 MULTU 0xFFFFFFFF*0xFFFFFFFF (FAST_MULT=0) -> busy 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done 1 cycle
//  2 MULT -3*5 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1; with FAST_MULT=1, same values at the start edge, busy never high
//  3 DIV -7/2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIV 7/-2 -> lo=-3, hi=1; DIVU 7/2 -> lo=3, hi=1
//  4 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234
//  5 MTHI 0xAAAA then MTLO 0x5555 on back-to-back edges -> hi=0xAAAA, lo=0x5555, busy=0;
//    a start during DIVU busy is ignored, and the DIVU result is intact
//  6 reset asserted mid-CALC at iteration 10 -> hi=lo=0, busy=0, done=0 immediately;
//    a new MULTU 3*4 issued afterwards -> lo=12, hi=0
//  Bench also runs WIDTH=8 with exhaustive signed/unsigned mul/div against a reference model checking
//  in_1 = lo*in_2 + hi.

Source files
------------

// File: rtl/hilo_muldiv_iter.sv
// Multi-cycle HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Also holds the architectural HI/LO registers written by MTHI/MTLO.
module hilo_muldiv_iter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FAST_MULT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 is_signed;
  logic [WIDTH-1:0]     mag_1, mag_2;
  logic [2*WIDTH-1:0]   prod_u, prod_s;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     quo, rem;

  assign is_signed = op[2];
  // Negating the most-negative value wraps back to itself, which reads correctly as 2^(WIDTH-1).
  assign mag_1 = (is_signed && in_1[WIDTH-1]) ? -in_1 : in_1;
  assign mag_2 = (is_signed && in_2[WIDTH-1]) ? -in_2 : in_2;

  assign prod_u = {{WIDTH{1'b0}}, in_1} * {{WIDTH{1'b0}}, in_2};
  assign prod_s = {{WIDTH{in_1[WIDTH-1]}}, in_1} * {{WIDTH{in_2[WIDTH-1]}}, in_2};

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_step  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op[2:1] == 2'b00) begin
            if (op[0]) lo_d = in_1;
            else       hi_d = in_1;
          end else if (op[1]) begin
            if (FAST_MULT != 0 && !op[0]) begin
              {hi_d, lo_d} = is_signed ? prod_s : prod_u;
              done_d       = 1'b1;
            end else begin
              state_d   = StCalc;
              count_d   = '0;
              is_div_d  = op[0];
              neg_res_d = is_signed & (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
              neg_rem_d = is_signed & in_1[WIDTH-1];
              opnd_d    = op[0] ? mag_2 : mag_1;
              acc_d     = {{WIDTH{1'b0}}, (op[0] ? mag_1 : mag_2)};
            end
          end
        end
      end
      StCalc: begin
        acc_d   = is_div_q ? div_step : mul_step;
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          // Zero divisor leaves |dividend| as remainder, so hi recovers in_1 after sign fix.
          lo_d = (opnd_q == '0) ? '1 : (neg_res_q ? -quo : quo);
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
